// File: rtl/ball_move_arbiter_pkg.sv
// Shared labyrinth definitions: move directions, arbiter FSM states and default maze geometry.
// Direction encoding matches the bit index of the incoming move pulse vectors.
package labyrinth_pkg;

  localparam int DEF_MAZE_W  = 32;
  localparam int DEF_MAZE_H  = 32;
  localparam int DEF_COORD_W = 5;
  localparam int DEF_ADDR_W  = 10;

  typedef enum logic [1:0] {
    DIR_PX = 2'd0,
    DIR_NX = 2'd1,
    DIR_PY = 2'd2,
    DIR_NY = 2'd3
  } dir_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Lowest set bit wins when a source raises several directions at once.
  function automatic dir_e pulse_to_dir(input logic [3:0] p);
    dir_e d;
    d = DIR_NY;
    if (p[0])      d = DIR_PX;
    else if (p[1]) d = DIR_NX;
    else if (p[2]) d = DIR_PY;
    return d;
  endfunction

endpackage

// File: rtl/ball_move_arbiter_if.sv
// Single-port maze map read handshake shared with the renderer's read mux.
// master = move arbiter (issues reads), slave = map memory side.
interface ball_move_arbiter_if #(
  parameter int ADDR_W = 10
);
  logic              map_rd_req;
  logic [ADDR_W-1:0] map_rd_addr;
  logic              map_rd_valid;
  logic              map_rd_wall;

  modport master (
    output map_rd_req,
    output map_rd_addr,
    input  map_rd_valid,
    input  map_rd_wall
  );

  modport slave (
    input  map_rd_req,
    input  map_rd_addr,
    output map_rd_valid,
    output map_rd_wall
  );
endinterface

// File: rtl/ball_move_arbiter_move_req_slot.sv
// One-deep pending move slot per source: priority-encodes pulses, holds the direction until granted.
// A pulse seen while the slot is full and not being granted this cycle is reported as a drop.
module move_req_slot
  import labyrinth_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic [3:0] pulses,
  input  logic       grant,
  output logic       pend,
  output dir_e       dir,
  output logic       drop
);

  logic any;

  assign any  = |pulses;
  assign drop = !clear && any && pend && !grant;

  // Grant frees the slot in the same edge that can capture a new pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= 1'b0;
      dir  <= DIR_PX;
    end else if (clear) begin
      pend <= 1'b0;
    end else if (any && (!pend || grant)) begin
      pend <= 1'b1;
      dir  <= pulse_to_dir(pulses);
    end else if (grant) begin
      pend <= 1'b0;
    end
  end

endmodule

// File: rtl/ball_move_arbiter.sv
// Arbitrates accel/button moves, validates them against the wall map and owns the ball position.
// Pulse->new position in 4 cycles with a 1-cycle map; MOVE_COUNTER_EN adds a saturating move counter.
module ball_move_arbiter
  import labyrinth_pkg::*;
#(
  parameter int MAZE_W  = DEF_MAZE_W,
  parameter int MAZE_H  = DEF_MAZE_H,
  parameter int COORD_W = DEF_COORD_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int START_X = 0,
  parameter int START_Y = 0,
  parameter int GOAL_X  = 31,
  parameter int GOAL_Y  = 31,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               game_en,
  input  logic [3:0]         accel_pulses,
  input  logic [3:0]         btn_pulses,
  ball_move_arbiter_if.master map,
  output logic [COORD_W-1:0] ball_x,
  output logic [COORD_W-1:0] ball_y,
  output logic               busy,
  output logic               blocked,
  output logic               map_err,
  output logic               goal_reached,
  output logic [7:0]         drop_count,
  output logic [15:0]        move_count
);

  localparam int TMO_W = $clog2(TIMEOUT + 2);
  localparam logic [COORD_W-1:0] X_MAX   = COORD_W'(MAZE_W - 1);
  localparam logic [COORD_W-1:0] Y_MAX   = COORD_W'(MAZE_H - 1);
  localparam logic [COORD_W-1:0] START_XC = COORD_W'(START_X);
  localparam logic [COORD_W-1:0] START_YC = COORD_W'(START_Y);
  localparam logic [COORD_W-1:0] GOAL_XC  = COORD_W'(GOAL_X);
  localparam logic [COORD_W-1:0] GOAL_YC  = COORD_W'(GOAL_Y);

  state_e state, state_nxt;

  logic             take;
  logic [3:0]       a_in, b_in;
  logic             a_pend, b_pend, a_drop, b_drop;
  dir_e             a_dir, b_dir, gnt_dir;
  logic             arb_idle, gnt_a, gnt_b, gnt_any;
  logic             last_btn;

  logic [COORD_W-1:0] tx, ty, tx_q, ty_q;
  logic               in_range;
  logic [ADDR_W-1:0]  tgt_addr, addr_q;
  logic [TMO_W-1:0]   tmo_cnt;

  logic blk_nxt, ld_tgt, upd_ball, err_set, goal_set, rd_req, cnt_clr, cnt_inc;

  // Nothing is latched or counted as dropped once the goal is reached.
  assign take = game_en && (state != DONE);
  assign a_in = take ? accel_pulses : 4'b0000;
  assign b_in = take ? btn_pulses   : 4'b0000;

  move_req_slot u_accel_slot (
    .clk    (clk),
    .rst_n  (reset),
    .clear  (!game_en),
    .pulses (a_in),
    .grant  (gnt_a),
    .pend   (a_pend),
    .dir    (a_dir),
    .drop   (a_drop)
  );

  move_req_slot u_btn_slot (
    .clk    (clk),
    .rst_n  (reset),
    .clear  (!game_en),
    .pulses (b_in),
    .grant  (gnt_b),
    .pend   (b_pend),
    .dir    (b_dir),
    .drop   (b_drop)
  );

  // last_btn only moves on contended grants, so a lone grant does not steal the next turn.
  assign arb_idle = (state == IDLE) && game_en;
  assign gnt_a    = arb_idle && a_pend && (!b_pend || last_btn);
  assign gnt_b    = arb_idle && b_pend && (!a_pend || !last_btn);
  assign gnt_any  = gnt_a || gnt_b;
  assign gnt_dir  = gnt_a ? a_dir : b_dir;

  always_comb begin
    tx       = ball_x;
    ty       = ball_y;
    in_range = 1'b1;
    case (gnt_dir)
      DIR_PX: if (ball_x == X_MAX) in_range = 1'b0; else tx = ball_x + COORD_W'(1);
      DIR_NX: if (ball_x == '0)    in_range = 1'b0; else tx = ball_x - COORD_W'(1);
      DIR_PY: if (ball_y == Y_MAX) in_range = 1'b0; else ty = ball_y + COORD_W'(1);
      DIR_NY: if (ball_y == '0)    in_range = 1'b0; else ty = ball_y - COORD_W'(1);
      default: in_range = 1'b0;
    endcase
  end

  assign tgt_addr = ADDR_W'(ty) * ADDR_W'(MAZE_W) + ADDR_W'(tx);

  always_comb begin
    state_nxt = state;
    blk_nxt   = 1'b0;
    ld_tgt    = 1'b0;
    upd_ball  = 1'b0;
    err_set   = 1'b0;
    goal_set  = 1'b0;
    rd_req    = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_any) begin
          if (in_range) begin
            ld_tgt    = 1'b1;
            state_nxt = REQ;
          end else begin
            blk_nxt = 1'b1;
          end
        end
      end
      REQ: begin
        rd_req    = 1'b1;
        cnt_clr   = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (map.map_rd_valid) begin
          if (map.map_rd_wall) begin
            blk_nxt   = 1'b1;
            state_nxt = IDLE;
          end else begin
            upd_ball  = 1'b1;
            state_nxt = CHECK;
          end
        end else if (tmo_cnt == TMO_W'(TIMEOUT)) begin
          err_set   = 1'b1;
          blk_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      CHECK: begin
        if ((ball_x == GOAL_XC) && (ball_y == GOAL_YC)) begin
          goal_set  = 1'b1;
          state_nxt = DONE;
        end else begin
          state_nxt = IDLE;
        end
      end
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ball_x       <= START_XC;
      ball_y       <= START_YC;
      tx_q         <= '0;
      ty_q         <= '0;
      addr_q       <= '0;
      tmo_cnt      <= '0;
      blocked      <= 1'b0;
      map_err      <= 1'b0;
      goal_reached <= 1'b0;
      drop_count   <= 8'd0;
      last_btn     <= 1'b1;
    end else begin
      blocked <= blk_nxt;
      if (ld_tgt) begin
        tx_q   <= tx;
        ty_q   <= ty;
        addr_q <= tgt_addr;
      end
      if (cnt_clr)      tmo_cnt <= '0;
      else if (cnt_inc) tmo_cnt <= tmo_cnt + TMO_W'(1);
      if (upd_ball) begin
        ball_x <= tx_q;
        ball_y <= ty_q;
      end
      if (err_set)  map_err      <= 1'b1;
      if (goal_set) goal_reached <= 1'b1;
      if ((a_drop || b_drop) && (drop_count != 8'hFF)) drop_count <= drop_count + 8'd1;
      if (arb_idle && a_pend && b_pend) last_btn <= gnt_b;
    end
  end

`ifdef MOVE_COUNTER_EN
  logic [15:0] move_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                move_cnt_q <= 16'd0;
    else if (upd_ball && move_cnt_q != 16'hFFFF) move_cnt_q <= move_cnt_q + 16'd1;
  end

  assign move_count = move_cnt_q;
`else
  assign move_count = 16'd0;
`endif

  assign map.map_rd_req  = rd_req;
  assign map.map_rd_addr = addr_q;
  assign busy            = (state != IDLE);

endmodule

// File: tb/tb_ball_move_arbiter.sv
// Self-checking bench: vector table of moves plus hand sequences for latency, arbitration, timeout, goal and reset.
module tb_ball_move_arbiter;
  import labyrinth_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        game_en = 1'b0;
  logic [3:0]  accel_pulses = 4'b0;
  logic [3:0]  btn_pulses = 4'b0;
  logic [4:0]  ball_x, ball_y;
  logic        busy, blocked, map_err, goal_reached;
  logic [7:0]  drop_count;
  logic [15:0] move_count;

  ball_move_arbiter_if #(.ADDR_W(10)) mif ();

  ball_move_arbiter dut (
    .clk          (clk),
    .reset        (rst_n),
    .game_en      (game_en),
    .accel_pulses (accel_pulses),
    .btn_pulses   (btn_pulses),
    .map          (mif),
    .ball_x       (ball_x),
    .ball_y       (ball_y),
    .busy         (busy),
    .blocked      (blocked),
    .map_err      (map_err),
    .goal_reached (goal_reached),
    .drop_count   (drop_count),
    .move_count   (move_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int blk_cnt = 0;
  int last_req_cyc = 0;
  int mx = 0, my = 0, moves_exp = 0;
  logic stall = 1'b0;
  logic rsp_vld = 1'b0, rsp_wall = 1'b0, late_vld = 1'b0;
  logic maze [0:1023];
  logic [9:0] exp_addr_q [$];
  logic [9:0] sb_addr;

  assign mif.map_rd_valid = rsp_vld | late_vld;
  assign mif.map_rd_wall  = rsp_wall;

  typedef struct {
    bit         src;
    logic [3:0] p;
    int         ex;
    int         ey;
    int         eb;
  } vec_t;
  vec_t tbl [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
    end
  endtask

  always @(posedge clk) cyc++;
  always @(negedge clk) if (blocked) blk_cnt++;

  // Map model and scoreboard: every read strobe must match the next predicted address.
  initial begin
    forever begin
      @(negedge clk);
      if (mif.map_rd_req) begin
        last_req_cyc = cyc;
        if (exp_addr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: got addr %0d, expected no read", mif.map_rd_addr);
        end else begin
          sb_addr = exp_addr_q.pop_front();
          chk("req_addr", 32'(mif.map_rd_addr), 32'(sb_addr));
        end
        if (!stall) begin
          @(posedge clk); #1;
          rsp_vld  = 1'b1;
          rsp_wall = maze[mif.map_rd_addr];
          @(posedge clk); #1;
          rsp_vld  = 1'b0;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic model_move(input logic [3:0] p);
    int tx, ty;
    tx = mx; ty = my;
    if (p[0])      tx++;
    else if (p[1]) tx--;
    else if (p[2]) ty++;
    else if (p[3]) ty--;
    if (tx < 0 || tx > 31 || ty < 0 || ty > 31) return;
    exp_addr_q.push_back(10'(ty * 32 + tx));
    if (!maze[ty * 32 + tx]) begin
      mx = tx; my = ty; moves_exp++;
    end
  endtask

  task automatic pulse(input bit src, input logic [3:0] p);
    @(posedge clk); #1;
    if (src) btn_pulses = p; else accel_pulses = p;
    @(posedge clk); #1;
    accel_pulses = 4'b0;
    btn_pulses   = 4'b0;
  endtask

  task automatic do_move(input bit src, input logic [3:0] p);
    model_move(p);
    pulse(src, p);
    repeat (5) @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [15:0] exp_mc();
`ifdef MOVE_COUNTER_EN
    return 16'(moves_exp);
`else
    return 16'd0;
`endif
  endfunction

  initial begin
    int b0, d0, blk_cyc, mc_x, mc_y;
    bit seen;

    for (int i = 0; i < 1024; i++) maze[i] = 1'b0;
    maze[2 * 32 + 2] = 1'b1;

    tbl[0]  = '{1'b0, 4'b0100, 0, 1, 0};
    tbl[1]  = '{1'b1, 4'b0010, 0, 1, 1};
    tbl[2]  = '{1'b0, 4'b0001, 1, 1, 0};
    tbl[3]  = '{1'b1, 4'b0100, 1, 2, 0};
    tbl[4]  = '{1'b0, 4'b0001, 1, 2, 1};
    tbl[5]  = '{1'b1, 4'b0100, 1, 3, 0};
    tbl[6]  = '{1'b0, 4'b0001, 2, 3, 0};
    tbl[7]  = '{1'b1, 4'b0101, 3, 3, 0};
    tbl[8]  = '{1'b0, 4'b1000, 3, 2, 0};
    tbl[9]  = '{1'b1, 4'b1010, 3, 2, 1};
    tbl[10] = '{1'b0, 4'b1100, 3, 3, 0};

    #1;
    chk("rst_ball_x", 32'(ball_x), 0);
    chk("rst_ball_y", 32'(ball_y), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_blocked", 32'(blocked), 0);
    chk("rst_map_err", 32'(map_err), 0);
    chk("rst_goal", 32'(goal_reached), 0);
    chk("rst_drop", 32'(drop_count), 0);
    chk("rst_move_count", 32'(move_count), 0);
    chk("rst_req", 32'(mif.map_rd_req), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    game_en = 1'b1;

    for (int i = 0; i < 11; i++) begin
      b0 = blk_cnt;
      do_move(tbl[i].src, tbl[i].p);
      chk($sformatf("vec%0d_x", i), 32'(ball_x), 32'(tbl[i].ex));
      chk($sformatf("vec%0d_y", i), 32'(ball_y), 32'(tbl[i].ey));
      chk($sformatf("vec%0d_blocked", i), 32'(blk_cnt - b0), 32'(tbl[i].eb));
    end
    chk("table_move_count", 32'(move_count), 32'(exp_mc()));

    // Latency: pulse in cycle t, req t+2, new position visible t+4, busy for 3 cycles.
    model_move(4'b0001);
    @(posedge clk); #1; accel_pulses = 4'b0001;
    @(posedge clk); #1; accel_pulses = 4'b0000;
    @(negedge clk);
    chk("lat_t1_req", 32'(mif.map_rd_req), 0);
    chk("lat_t1_busy", 32'(busy), 0);
    @(negedge clk);
    chk("lat_t2_req", 32'(mif.map_rd_req), 1);
    chk("lat_t2_addr", 32'(mif.map_rd_addr), 100);
    chk("lat_t2_busy", 32'(busy), 1);
    @(negedge clk);
    chk("lat_t3_busy", 32'(busy), 1);
    chk("lat_t3_x_old", 32'(ball_x), 3);
    @(negedge clk);
    chk("lat_t4_busy", 32'(busy), 1);
    chk("lat_t4_x_new", 32'(ball_x), 4);
    @(negedge clk);
    chk("lat_t5_busy", 32'(busy), 0);

    // Contended pairs: accel wins first, then the pointer favours btn.
    exp_addr_q.push_back(10'(4 * 32 + 4));
    exp_addr_q.push_back(10'(4 * 32 + 5));
    @(posedge clk); #1; accel_pulses = 4'b0100; btn_pulses = 4'b0001;
    @(posedge clk); #1; accel_pulses = 4'b0000; btn_pulses = 4'b0000;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("rr1_x", 32'(ball_x), 5);
    chk("rr1_y", 32'(ball_y), 4);
    exp_addr_q.push_back(10'(4 * 32 + 6));
    exp_addr_q.push_back(10'(5 * 32 + 6));
    @(posedge clk); #1; accel_pulses = 4'b0100; btn_pulses = 4'b0001;
    @(posedge clk); #1; accel_pulses = 4'b0000; btn_pulses = 4'b0000;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("rr2_x", 32'(ball_x), 6);
    chk("rr2_y", 32'(ball_y), 5);
    mx = 6; my = 5; moves_exp += 4;

    // Stalled map: refill the slot, then drop, then time out.
    stall = 1'b1;
    exp_addr_q.push_back(10'(5 * 32 + 7));
    b0 = blk_cnt;
    pulse(1'b0, 4'b0001);
    pulse(1'b0, 4'b0001);
    pulse(1'b0, 4'b0001);
    @(negedge clk);
    chk("drop_one", 32'(drop_count), 1);
    chk("err_before_tmo", 32'(map_err), 0);
    seen = 1'b0;
    blk_cyc = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (blocked) begin
        seen = 1'b1;
        blk_cyc = cyc;
        exp_addr_q.push_back(10'(5 * 32 + 7));
        stall = 1'b0;
      end
    end
    chk("tmo_blocked_seen", 32'(seen), 1);
    chk("tmo_map_err", 32'(map_err), 1);
    chk("tmo_window", 32'((blk_cyc - last_req_cyc) >= 15 && (blk_cyc - last_req_cyc) <= 18), 1);
    stall = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("retry_x", 32'(ball_x), 7);
    chk("retry_y", 32'(ball_y), 5);
    chk("tmo_pos_blocked_total", 32'(blk_cnt - b0), 1);
    mx = 7; moves_exp++;

    // Disabled game: pulses ignored, nothing read.
    game_en = 1'b0;
    pulse(1'b0, 4'b0001);
    pulse(1'b1, 4'b0100);
    repeat (4) @(posedge clk); #1;
    game_en = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("dis_x", 32'(ball_x), 7);
    chk("dis_y", 32'(ball_y), 5);
    chk("dis_drop", 32'(drop_count), 1);

    for (int i = 0; i < 23; i++) do_move(1'b0, 4'b0001);
    for (int i = 0; i < 26; i++) do_move(1'b1, 4'b0100);
    chk("walk_x", 32'(ball_x), 30);
    chk("walk_y", 32'(ball_y), 31);
    b0 = blk_cnt;
    do_move(1'b1, 4'b0100);
    chk("ymax_blocked", 32'(blk_cnt - b0), 1);
    chk("ymax_y", 32'(ball_y), 31);
    do_move(1'b0, 4'b0001);
    chk("goal_x", 32'(ball_x), 31);
    chk("goal_flag", 32'(goal_reached), 1);
    chk("goal_busy_done", 32'(busy), 1);
    chk("goal_move_count", 32'(move_count), 32'(exp_mc()));

    d0 = drop_count;
    pulse(1'b0, 4'b0010);
    pulse(1'b0, 4'b0010);
    pulse(1'b1, 4'b1000);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("done_no_drop", 32'(drop_count), 32'(d0));
    chk("done_hold_x", 32'(ball_x), 31);
    chk("done_goal_sticky", 32'(goal_reached), 1);

    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rst_done_goal", 32'(goal_reached), 0);
    chk("rst_done_x", 32'(ball_x), 0);
    chk("rst_done_y", 32'(ball_y), 0);
    chk("rst_done_err", 32'(map_err), 0);
    chk("rst_done_drop", 32'(drop_count), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_addr_q.delete();
    mx = 0; my = 0; moves_exp = 0;

    do_move(1'b0, 4'b0001);
    chk("post_rst_x", 32'(ball_x), 1);

    // Reset while a read is outstanding, then a late valid that must be ignored.
    stall = 1'b1;
    exp_addr_q.push_back(10'(1 * 32 + 1));
    pulse(1'b0, 4'b0100);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("midwait_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("midwait_rst_x", 32'(ball_x), 0);
    chk("midwait_rst_y", 32'(ball_y), 0);
    chk("midwait_rst_busy", 32'(busy), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    stall = 1'b0;
    exp_addr_q.delete();
    mx = 0; my = 0; moves_exp = 0;
    b0 = blk_cnt;
    late_vld = 1'b1;
    @(posedge clk); #1;
    late_vld = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("late_vld_x", 32'(ball_x), 0);
    chk("late_vld_y", 32'(ball_y), 0);
    chk("late_vld_busy", 32'(busy), 0);
    chk("late_vld_blocked", 32'(blk_cnt - b0), 0);

    do_move(1'b1, 4'b0100);
    mc_x = ball_x;
    mc_y = ball_y;
    chk("final_x", 32'(mc_x), 0);
    chk("final_y", 32'(mc_y), 1);
    chk("final_move_count", 32'(move_count), 32'(exp_mc()));
    chk("sb_empty", 32'(exp_addr_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
